dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and waits a fixed number of cycles. It then performs the RISC-V byte, halfword or word access on an internal word array and returns the result over a valid/ready response channel. It replaces the zero-wait, word-only data memory behind the datapath's `MemRead`/`MemWrite`, so that the pipelined core can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 79 +++++++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and funct3 legality helper for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_t;

  // Stores only know B/H/W; loads add the unsigned byte/halfword forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extraction/extension, store byte-merge and error flag.
// DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors instead of aligning them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword,
  output logic        o_wen,
  output logic        o_err
);

  logic       w_is_half;
  logic       w_is_word;
  logic       w_misalign;
  logic       w_err;
  logic [1:0] w_off;
  logic [4:0] w_sh;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  // Access size, effective lane offset and error decode
  always_comb begin
    w_is_half  = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
    w_is_word  = (i_funct3 == F3_W);
    w_misalign = (w_is_half && i_addr_lo[0]) || (w_is_word && (i_addr_lo != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    w_err = ~f3_legal(i_we, i_funct3) | w_misalign;
    w_off = i_addr_lo;
`else
    w_err = ~f3_legal(i_we, i_funct3);
    if (w_is_word) begin
      w_off = 2'b00;
    end else if (w_is_half) begin
      w_off = {i_addr_lo[1], 1'b0};
    end else begin
      w_off = i_addr_lo;
    end
`endif
    w_sh = {w_off, 3'b000};
  end

  // Load lane extraction with sign or zero extension
  always_comb begin
    w_byte  = i_rword[w_sh +: 8];
    w_half  = w_off[1] ? i_rword[31:16] : i_rword[15:0];
    o_rdata = 32'h0000_0000;
    if (!i_we && !w_err) begin
      case (i_funct3)
        F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
        F3_BU:   o_rdata = {24'h00_0000, w_byte};
        F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
        F3_HU:   o_rdata = {16'h0000, w_half};
        F3_W:    o_rdata = i_rword;
        default: o_rdata = 32'h0000_0000;
      endcase
    end else begin
      o_rdata = 32'h0000_0000;
    end
  end

  // Store merge: untouched lanes keep the current word
  always_comb begin
    o_wword = i_rword;
    case (i_funct3)
      F3_B:    o_wword[w_sh +: 8]  = i_wdata[7:0];
      F3_H:    o_wword[w_sh +: 16] = i_wdata[15:0];
      F3_W:    o_wword             = i_wdata;
      default: o_wword             = i_rword;
    endcase
    o_wen = i_we & ~w_err;
    o_err = w_err;
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: valid/ready request in, RISC-V B/H/W access, valid/ready response out.
// Optional DMEM_MISALIGN_TRAP_EN reports misaligned H/W accesses as errors (handled in dmem_lane_align).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  localparam logic             LAT0  = (LAT == 0);

  dmem_state_t      r_state;
  dmem_state_t      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [AW+1:0]    r_addr;
  logic [2:0]       r_funct3;
  logic [31:0]      r_wdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  logic [31:0]      r_mem [DEPTH];

  logic             w_accept;
  logic             w_exec;
  logic             w_use_req;
  logic             w_we;
  logic [AW+1:0]    w_addr;
  logic [2:0]       w_funct3;
  logic [31:0]      w_wdata;
  logic [AW-1:0]    w_idx;
  logic [31:0]      w_rword;
  logic [31:0]      w_rdata;
  logic [31:0]      w_wword;
  logic             w_wen;
  logic             w_err;
  logic             w_unused;

  assign w_unused  = ^req_addr[31:AW+2];
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // With zero latency the access happens on the accept edge, so the live request feeds the lanes
  always_comb begin
    w_accept  = req_valid & (r_state == ST_IDLE);
    w_use_req = (r_state == ST_IDLE);
    w_exec    = (w_accept & LAT0) | ((r_state == ST_WAIT) & (r_cnt == 4'd1));
    if (w_use_req) begin
      w_we     = req_we;
      w_addr   = req_addr[AW+1:0];
      w_funct3 = req_funct3;
      w_wdata  = req_wdata;
    end else begin
      w_we     = r_we;
      w_addr   = r_addr;
      w_funct3 = r_funct3;
      w_wdata  = r_wdata;
    end
    w_idx   = w_addr[AW+1:2];
    w_rword = r_mem[w_idx];
  end

  dmem_lane_align u_lane (
    .i_we      (w_we),
    .i_addr_lo (w_addr[1:0]),
    .i_funct3  (w_funct3),
    .i_rword   (w_rword),
    .i_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_wword   (w_wword),
    .o_wen     (w_wen),
    .o_err     (w_err)
  );

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = LAT0 ? ST_RESP : ST_WAIT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, wait counter, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_funct3    <= 3'b000;
      r_wdata     <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr[AW+1:0];
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
        r_cnt    <= LAT_C;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rdata;
        r_rsp_err   <= w_err;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= 32'h0000_0000;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  // Memory array is never cleared; a reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && w_exec && w_wen) begin
      r_mem[w_idx] <= w_wword;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (LAT=2 main instance, LAT=0 shadow instance).
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[18];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .LAT(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic txn(input vec_t v, input int id, input logic chk_z);
    int cyc;
    req_we = v.we; req_addr = v.addr; req_funct3 = v.f3; req_wdata = v.wdata;
    req_valid = 1'b1; rsp_ready = 1'b1;
    chk($sformatf("req_ready[%0d]", id), {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (chk_z) begin
      chk($sformatf("lat0_valid[%0d]", id), {31'd0, z_rsp_valid}, 32'd1);
      chk($sformatf("lat0_rdata[%0d]", id), z_rsp_rdata, v.exp_rdata);
      chk($sformatf("lat0_err[%0d]", id), {31'd0, z_rsp_err}, {31'd0, v.exp_err});
    end
    wait_rsp(cyc);
    chk($sformatf("latency[%0d]", id), 32'(cyc), 32'd3);
    chk($sformatf("rdata[%0d]", id), rsp_rdata, v.exp_rdata);
    chk($sformatf("err[%0d]", id), {31'd0, rsp_err}, {31'd0, v.exp_err});
    @(posedge clk); #1;
    chk($sformatf("rsp_drop[%0d]", id), {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    vec_t v;
    vecs[0]  = '{1'b1, 32'h10,  F3_W,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  F3_W,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h13,  F3_B,   32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, 32'h13,  F3_BU,  32'h0,        32'h000000DE, 1'b0};
    vecs[4]  = '{1'b0, 32'h10,  F3_H,   32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{1'b0, 32'h12,  F3_HU,  32'h0,        32'h0000DEAD, 1'b0};
    vecs[6]  = '{1'b1, 32'h11,  F3_B,   32'h000000AA, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h10,  F3_W,   32'h0,        32'hDEADAAEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h12,  F3_H,   32'h00001234, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h10,  F3_W,   32'h0,        32'h1234AAEF, 1'b0};
    vecs[10] = '{1'b1, 32'h10,  F3_BU,  32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h10,  F3_W,   32'h0,        32'h1234AAEF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[12] = '{1'b0, 32'h12,  F3_W,   32'h0,        32'h0,        1'b1};
    vecs[17] = '{1'b0, 32'h13,  F3_H,   32'h0,        32'h0,        1'b1};
`else
    vecs[12] = '{1'b0, 32'h12,  F3_W,   32'h0,        32'h1234AAEF, 1'b0};
    vecs[17] = '{1'b0, 32'h13,  F3_H,   32'h0,        32'h00001234, 1'b0};
`endif
    vecs[13] = '{1'b1, 32'h20,  F3_W,   32'h11111111, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h11,  F3_B,   32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[15] = '{1'b0, 32'h10,  3'b011, 32'h0,        32'h0,        1'b1};
    vecs[16] = '{1'b0, 32'h110, F3_W,   32'h0,        32'h1234AAEF, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);

    for (int i = 0; i < 18; i++) txn(vecs[i], i, 1'b1);

    // Backpressure: response held stable for 5 cycles, request inputs ignored meanwhile
    req_we = 1'b0; req_addr = 32'h12; req_funct3 = F3_HU; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(cyc);
    chk("bp_latency", 32'(cyc), 32'd3);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = F3_W; req_wdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      chk($sformatf("bp_valid[%0d]", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_rdata[%0d]", k), rsp_rdata, 32'h00001234);
      chk($sformatf("bp_req_ready[%0d]", k), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    v = '{1'b0, 32'h10, F3_W, 32'h0, 32'h1234AAEF, 1'b0};
    txn(v, 100, 1'b0);

    // Reset in the second WAIT cycle drops the pending store
    req_we = 1'b1; req_addr = 32'h20; req_funct3 = F3_W; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wait_rsp_err", {31'd0, rsp_err}, 32'd0);
    v = '{1'b0, 32'h20, F3_W, 32'h0, 32'h11111111, 1'b0};
    txn(v, 101, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
